bmain_arb: RTL and testbench
============================

Name: bmain_arb

Overview:
Main-bus arbiter sharing the single DRAM controller port (command, write-data and read-data channels, 4-beat bursts) between NM requesters, such as icache and dcache.
- Grants one requester at a time, round-robin, and holds the grant for a whole burst.
- Routes the handshakes of the granted requester to and from the controller.
- Checks burst framing against an internal beat counter.
- Sits between the cache refill/writeback engines and the DRAM controller.

Parameters:
NM, 2, number of requesters (2..4)
BEATS, 4, data beats per burst; must match the controller

Ports:
clk_core  in  1  core clock
reset  in  1  synchronous, active-high reset
m_cvalid  in  [NM-1:0]  per-requester command valid
arb_cready  out  [NM-1:0]  per-requester command ready
m_cmd  in  [NM-1:0]  1=read, 0=write
m_addr  in  [NM-1:0][27:2]  burst word address
m_wvalid  in  [NM-1:0]  write-data valid
arb_wready  out  [NM-1:0]  write-data ready
m_wlast  in  [NM-1:0]  last write beat
m_wdata  in  [NM-1:0][31:0]  write data
m_wmask  in  [NM-1:0][3:0]  byte enables
arb_rvalid  out  [NM-1:0]  read-data valid
m_rready  in  [NM-1:0]  read-data ready
arb_rlast  out  [NM-1:0]  last read beat
arb_rdata  out  [31:0]  read data, broadcast to all requesters; qualified by arb_rvalid
bmain_cvalid_dctl  out  1  command valid to controller
dctl_cready  in  1
bmain_cmd  out  1
bmain_addr  out  [27:2]
bmain_wvalid_dctl  out  1
dctl_wready  in  1
bmain_wlast  out  1
bmain_wdata  out  [31:0]
bmain_wmask  out  [3:0]
dctl_rvalid  in  1
bmain_rready_dctl  out  1
dctl_rlast  in  1
dctl_rdata  in  [31:0]
dctl_error  in  1  controller error
arb_error  out  1  sticky error flag
arb_grant  out  [NM-1:0]  one-hot current owner; 0 when IDLE

Behaviour:
- Reset: state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, arb_error=0. All valid/ready outputs are 0 in reset and IDLE.
- All outputs to the controller are combinational muxes of the granted requester's signals, gated by state. Only the granted requester's ready/valid may be 1; all others are 0.

State machine (states IDLE, CMD, WDATA, RDATA):
- IDLE: if any m_cvalid, pick the first requester at or after rr_ptr (wrapping modulo NM). Register that grant; next state is CMD.
  - No command passes through in IDLE, so grant-to-command latency is 1 cycle.
- CMD: bmain_cvalid_dctl=m_cvalid[g]; bmain_cmd and bmain_addr taken from requester g; arb_cready[g]=dctl_cready.
  - On the command beat, clear beat_cnt. Go to RDATA if cmd=1, else WDATA.
  - If m_cvalid[g] drops before the beat, set arb_error and return to IDLE.
- WDATA: forward wvalid, wlast, wdata and wmask from g; arb_wready[g]=dctl_wready.
  - Each write beat increments beat_cnt.
  - If m_wlast[g] on a beat disagrees with (beat_cnt==BEATS-1), set arb_error.
  - Leave on the beat where beat_cnt==BEATS-1, regardless of wlast.
- RDATA: arb_rvalid[g]=dctl_rvalid, arb_rlast[g]=dctl_rlast, bmain_rready_dctl=m_rready[g].
  - Each read beat increments beat_cnt; dctl_rlast is checked the same way as wlast.
  - Leave on the read beat where beat_cnt==BEATS-1.
- Exit from WDATA/RDATA: go to IDLE, set rr_ptr=(g+1) mod NM, set grant=0.
  - A new grant can be issued the cycle after IDLE is entered, so the minimum gap between bursts is 2 cycles.

Boundary cases:
- beat_cnt is $clog2(BEATS) bits wide and wraps.
- Exactly one transaction is outstanding at a time; no interleaving.
- Requests that arrive during a burst are held pending and are not dropped.
- dctl_error=1 in any cycle sets arb_error. arb_error clears only on reset.
- Reset asserted mid-burst returns to IDLE immediately. The controller is reset by the same reset.

Decomposition:
- Shared package bmain_pkg: state enum bmain_arb_state_t {IDLE,CMD,WDATA,RDATA}; BMAIN_BEATS=4; BMAIN_CMD_READ=1'b1, BMAIN_CMD_WRITE=1'b0.
- One sub-module, rr_pick: combinational round-robin selector taking (req[NM-1:0], ptr) and producing a one-hot gnt plus a found flag.

Test Plan:
- Single read: requester 0 reads addr 0x0000040 with a preloaded dummy controller -> arb_grant=01 one cycle after cvalid; 4 arb_rvalid[0] beats; arb_rlast[0] on beat 4; rdata matches.
- Single write then read: requester 1 writes 0xA5A5_0000..0003 to 0x0000100, then reads it back -> data matches; arb_wready[0] stays 0 throughout.
- Contention: both cvalid asserted continuously from reset -> grants alternate 01,10,01,10; no starvation over 8 bursts.
- Backpressure: m_rready toggles 1,0,1,0 during a read -> bmain_rready_dctl mirrors it; no lost or duplicated beats; beat_cnt reaches 3 exactly once.
- Framing error: requester asserts wlast on beat 2 -> arb_error=1 the next cycle and stays 1; the FSM still completes 4 beats and returns to IDLE.
- Reset mid-burst: assert reset during RDATA beat 2 -> all outputs 0 the next cycle; arb_grant=0; arb_error=0; a new read afterwards completes normally.

Source files
------------

// File: rtl/bmain_pkg.sv
// Shared types and constants for the main-bus arbiter.
package bmain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } bmain_arb_state_t;

    localparam int   BMAIN_BEATS     = 4;
    localparam logic BMAIN_CMD_READ  = 1'b1;
    localparam logic BMAIN_CMD_WRITE = 1'b0;

endpackage

// File: rtl/bmain_arb_if.sv
// Bus bundle between the refill/writeback requesters, the arbiter and the
// DRAM controller. The slave view belongs to the arbiter; the master view
// belongs to whatever drives the requesters and the controller.
interface bmain_arb_if #(parameter int NM = 2);

    // requester side
    logic [NM-1:0]        m_cvalid;
    logic [NM-1:0]        arb_cready;
    logic [NM-1:0]        m_cmd;
    logic [NM-1:0][27:2]  m_addr;
    logic [NM-1:0]        m_wvalid;
    logic [NM-1:0]        arb_wready;
    logic [NM-1:0]        m_wlast;
    logic [NM-1:0][31:0]  m_wdata;
    logic [NM-1:0][3:0]   m_wmask;
    logic [NM-1:0]        arb_rvalid;
    logic [NM-1:0]        m_rready;
    logic [NM-1:0]        arb_rlast;
    logic [31:0]          arb_rdata;

    // controller side
    logic                 bmain_cvalid_dctl;
    logic                 dctl_cready;
    logic                 bmain_cmd;
    logic [27:2]          bmain_addr;
    logic                 bmain_wvalid_dctl;
    logic                 dctl_wready;
    logic                 bmain_wlast;
    logic [31:0]          bmain_wdata;
    logic [3:0]           bmain_wmask;
    logic                 dctl_rvalid;
    logic                 bmain_rready_dctl;
    logic                 dctl_rlast;
    logic [31:0]          dctl_rdata;
    logic                 dctl_error;

    // status
    logic                 arb_error;
    logic [NM-1:0]        arb_grant;

    modport slave (
        input  m_cvalid, m_cmd, m_addr, m_wvalid, m_wlast, m_wdata, m_wmask, m_rready,
        input  dctl_cready, dctl_wready, dctl_rvalid, dctl_rlast, dctl_rdata, dctl_error,
        output arb_cready, arb_wready, arb_rvalid, arb_rlast, arb_rdata,
        output bmain_cvalid_dctl, bmain_cmd, bmain_addr, bmain_wvalid_dctl, bmain_wlast,
        output bmain_wdata, bmain_wmask, bmain_rready_dctl, arb_error, arb_grant
    );

    modport master (
        output m_cvalid, m_cmd, m_addr, m_wvalid, m_wlast, m_wdata, m_wmask, m_rready,
        output dctl_cready, dctl_wready, dctl_rvalid, dctl_rlast, dctl_rdata, dctl_error,
        input  arb_cready, arb_wready, arb_rvalid, arb_rlast, arb_rdata,
        input  bmain_cvalid_dctl, bmain_cmd, bmain_addr, bmain_wvalid_dctl, bmain_wlast,
        input  bmain_wdata, bmain_wmask, bmain_rready_dctl, arb_error, arb_grant
    );

endinterface

// File: rtl/bmain_arb_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after
// ptr, wrapping modulo NM. Returns one-hot grant, its index and a found flag.
module rr_pick #(
    parameter int NM = 2,
    parameter int IW = 1
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [NM-1:0] gnt,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan from ptr upwards and latch onto the first requester seen
    always_comb begin
        int cand;
        cand  = 0;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NM; k++) begin
            cand = ((int'(ptr) + k) >= NM) ? (int'(ptr) + k - NM) : (int'(ptr) + k);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
                found     = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/bmain_arb.sv
// Main-bus arbiter: shares one DRAM controller port between NM requesters,
// one whole 4-beat burst at a time, round-robin, with framing checks.
module bmain_arb
    import bmain_pkg::*;
#(
    parameter int NM    = 2,
    parameter int BEATS = BMAIN_BEATS
) (
    input  logic        clk_core,
    input  logic        reset,
    bmain_arb_if.slave  bus
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    bmain_arb_state_t state_q, state_d;
    logic [NM-1:0]    grant_q, grant_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic             error_q, error_d;

    logic [NM-1:0]    pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_found;
    logic             last_beat_s;
    logic             beat_s;
    logic [IW-1:0]    next_ptr_s;

    rr_pick #(.NM(NM), .IW(IW)) u_pick (
        .req   (bus.m_cvalid),
        .ptr   (rr_ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign last_beat_s   = (beat_cnt_q == CW'(BEATS - 1));
    assign next_ptr_s    = (gidx_q == IW'(NM - 1)) ? IW'(0) : (gidx_q + IW'(1));
    assign bus.arb_rdata = bus.dctl_rdata;
    assign bus.arb_error = error_q;
    assign bus.arb_grant = grant_q;

    // Next-state logic and routing of the granted requester's handshakes
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        error_d    = error_q;
        beat_s     = 1'b0;

        bus.arb_cready        = '0;
        bus.arb_wready        = '0;
        bus.arb_rvalid        = '0;
        bus.arb_rlast         = '0;
        bus.bmain_cvalid_dctl = 1'b0;
        bus.bmain_cmd         = 1'b0;
        bus.bmain_addr        = '0;
        bus.bmain_wvalid_dctl = 1'b0;
        bus.bmain_wlast       = 1'b0;
        bus.bmain_wdata       = 32'h0000_0000;
        bus.bmain_wmask       = 4'h0;
        bus.bmain_rready_dctl = 1'b0;

        case (state_q)
            IDLE: begin
                // grant is registered here; the command only passes next cycle
                if (pick_found) begin
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    state_d = CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            CMD: begin
                bus.bmain_cvalid_dctl      = bus.m_cvalid[gidx_q];
                bus.bmain_cmd              = bus.m_cmd[gidx_q];
                bus.bmain_addr             = bus.m_addr[gidx_q];
                bus.arb_cready[gidx_q]     = bus.dctl_cready;
                if (!bus.m_cvalid[gidx_q]) begin
                    // requester withdrew its command before it was taken
                    error_d = 1'b1;
                    grant_d = '0;
                    state_d = IDLE;
                end else if (bus.dctl_cready) begin
                    beat_cnt_d = '0;
                    state_d    = (bus.m_cmd[gidx_q] == BMAIN_CMD_READ) ? RDATA : WDATA;
                end else begin
                    state_d = CMD;
                end
            end
            WDATA: begin
                bus.bmain_wvalid_dctl  = bus.m_wvalid[gidx_q];
                bus.bmain_wlast        = bus.m_wlast[gidx_q];
                bus.bmain_wdata        = bus.m_wdata[gidx_q];
                bus.bmain_wmask        = bus.m_wmask[gidx_q];
                bus.arb_wready[gidx_q] = bus.dctl_wready;
                beat_s = bus.m_wvalid[gidx_q] & bus.dctl_wready;
                if (beat_s) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (bus.m_wlast[gidx_q] != last_beat_s) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = error_q;
                    end
                    // the beat counter, not wlast, decides where the burst ends
                    if (last_beat_s) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr_s;
                    end else begin
                        state_d = WDATA;
                    end
                end else begin
                    state_d = WDATA;
                end
            end
            RDATA: begin
                bus.arb_rvalid[gidx_q] = bus.dctl_rvalid;
                bus.arb_rlast[gidx_q]  = bus.dctl_rlast;
                bus.bmain_rready_dctl  = bus.m_rready[gidx_q];
                beat_s = bus.dctl_rvalid & bus.m_rready[gidx_q];
                if (beat_s) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (bus.dctl_rlast != last_beat_s) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = error_q;
                    end
                    if (last_beat_s) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr_s;
                    end else begin
                        state_d = RDATA;
                    end
                end else begin
                    state_d = RDATA;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // controller-reported faults are sticky alongside framing faults
        if (bus.dctl_error) begin
            error_d = 1'b1;
        end else begin
            error_d = error_d;
        end
    end

    // State and bookkeeping registers with synchronous reset
    always_ff @(posedge clk_core) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_bmain_arb.sv
// Directed bench for bmain_arb: drives requesters and a dummy controller,
// scoreboards read and write data through queues.
module tb_bmain_arb;

    logic clk_core = 1'b0;
    logic reset;

    bmain_arb_if #(.NM(2)) bus ();

    bmain_arb #(.NM(2), .BEATS(4)) dut (
        .clk_core (clk_core),
        .reset    (reset),
        .bus      (bus.slave)
    );

    always #5 clk_core = ~clk_core;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [logic [27:2]];
    logic [31:0] rq [$];
    logic [31:0] wq [$];
    bit   hold = 1'b0;
    int   exp_ptr = 0;
    int   grants_seen [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        bus.dctl_cready = 1'b0;
        bus.dctl_wready = 1'b0;
        bus.dctl_rvalid = 1'b0;
        bus.dctl_rlast  = 1'b0;
        bus.dctl_rdata  = 32'h0000_0000;
        bus.m_wvalid    = '0;
        bus.m_wlast     = '0;
        bus.m_rready    = '0;
    endtask

    // From IDLE: raise a command, check 1-cycle grant latency and the command beat
    task automatic issue(input int r, input logic rd, input logic [27:2] a);
        @(negedge clk_core);
        quiet();
        bus.m_cvalid[r] = 1'b1;
        bus.m_cmd[r]    = rd;
        bus.m_addr[r]   = a;
        #1;
        chk("idle_grant", 32'(bus.arb_grant), 32'd0);
        chk("idle_cvalid", 32'(bus.bmain_cvalid_dctl), 32'd0);
        @(negedge clk_core);
        chk("grant", 32'(bus.arb_grant), 32'd1 << r);
        chk("cmd_out", 32'({bus.bmain_cvalid_dctl, bus.bmain_cmd}), 32'({1'b1, rd}));
        chk("addr_out", 32'(bus.bmain_addr), 32'(a));
        bus.dctl_cready = 1'b1;
        #1;
        chk("cready", 32'(bus.arb_cready), 32'd1 << r);
        grants_seen[r]++;
        if (rd) begin
            for (int i = 0; i < 4; i++) rq.push_back(mem[a + 26'(i)]);
        end
    endtask

    // Read data phase; rpat toggles rready 1,0,1,0; stop_at>=0 returns at that beat
    task automatic read_data(input int r, input logic [27:2] a, input bit rpat, input int stop_at);
        int i = 0;
        int cyc = 0;
        logic rr;
        logic [31:0] exp;
        while (i < 4 && cyc < 40) begin
            @(negedge clk_core);
            if (cyc == 0) begin
                if (!hold) bus.m_cvalid[r] = 1'b0;
                bus.dctl_cready = 1'b0;
            end
            rr = rpat ? (cyc % 2 == 0) : 1'b1;
            bus.m_rready[r] = rr;
            bus.dctl_rvalid = 1'b1;
            bus.dctl_rdata  = mem[a + 26'(i)];
            bus.dctl_rlast  = (i == 3);
            #1;
            chk("rready_mirror", 32'(bus.bmain_rready_dctl), 32'(rr));
            chk("rvalid", 32'(bus.arb_rvalid), 32'd1 << r);
            chk("rlast", 32'(bus.arb_rlast), (i == 3) ? (32'd1 << r) : 32'd0);
            if (i == stop_at) return;
            if (rr) begin
                exp = rq.pop_front();
                chk("rdata", bus.arb_rdata, exp);
                i++;
            end
            cyc++;
        end
        chk("read_beats", 32'(i), 32'd4);
    endtask

    // Write data phase; wlast is raised on beat index wlast_beat
    task automatic write_data(input int r, input logic [27:2] a, input logic [31:0] base, input int wlast_beat);
        logic [31:0] d;
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_core);
            if (i == 0) begin
                bus.m_cvalid[r] = 1'b0;
                bus.dctl_cready = 1'b0;
            end
            d = base + 32'(i);
            bus.m_wvalid[r] = 1'b1;
            bus.m_wdata[r]  = d;
            bus.m_wmask[r]  = 4'hF;
            bus.m_wlast[r]  = (i == wlast_beat);
            bus.dctl_wready = 1'b1;
            wq.push_back(d);
            #1;
            chk("wvalid_out", 32'(bus.bmain_wvalid_dctl), 32'd1);
            chk("wready", 32'(bus.arb_wready), 32'd1 << r);
            chk("wlast_out", 32'(bus.bmain_wlast), 32'(i == wlast_beat));
            chk("wmask_out", 32'(bus.bmain_wmask), 32'hF);
            chk("err_during_wr", 32'(bus.arb_error), 32'(i > wlast_beat));
            exp = wq.pop_front();
            chk("wdata", bus.bmain_wdata, exp);
            mem[a + 26'(i)] = d;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:2] addrs [2];
        int r;
        reset = 1'b1;
        bus.m_cvalid = '0;
        bus.m_cmd    = '0;
        bus.m_addr   = '0;
        bus.m_wdata  = '0;
        bus.m_wmask  = '0;
        bus.dctl_error = 1'b0;
        quiet();
        for (int i = 0; i < 4; i++) mem[26'h40 + 26'(i)] = 32'hC0DE_0000 + 32'(i);
        grants_seen[0] = 0;
        grants_seen[1] = 0;

        // reset state
        repeat (3) @(negedge clk_core);
        #1;
        chk("rst_grant", 32'(bus.arb_grant), 32'd0);
        chk("rst_error", 32'(bus.arb_error), 32'd0);
        chk("rst_valids", 32'({bus.bmain_cvalid_dctl, bus.bmain_wvalid_dctl, bus.bmain_rready_dctl}), 32'd0);
        chk("rst_readies", 32'({bus.arb_cready, bus.arb_wready, bus.arb_rvalid}), 32'd0);
        reset = 1'b0;

        // single read by requester 0
        issue(0, 1'b1, 26'h40);
        read_data(0, 26'h40, 1'b0, -1);

        // write by requester 1, then read it back
        issue(1, 1'b0, 26'h100);
        write_data(1, 26'h100, 32'hA5A5_0000, 3);
        issue(1, 1'b1, 26'h100);
        read_data(1, 26'h100, 1'b0, -1);

        // read with rready backpressure
        issue(0, 1'b1, 26'h100);
        read_data(0, 26'h100, 1'b1, -1);
        exp_ptr = 1;

        // contention: both requesting continuously; grants must alternate
        hold = 1'b1;
        addrs[0] = 26'h40;
        addrs[1] = 26'h100;
        grants_seen[0] = 0;
        grants_seen[1] = 0;
        bus.m_cmd    = 2'b11;
        bus.m_addr[0] = addrs[0];
        bus.m_addr[1] = addrs[1];
        bus.m_cvalid = 2'b11;
        for (int b = 0; b < 8; b++) begin
            r = exp_ptr;
            issue(r, 1'b1, addrs[r]);
            read_data(r, addrs[r], 1'b0, -1);
            exp_ptr = (r + 1) % 2;
        end
        hold = 1'b0;
        bus.m_cvalid = '0;
        chk("fair_r0", 32'(grants_seen[0]), 32'd4);
        chk("fair_r1", 32'(grants_seen[1]), 32'd4);

        // framing error: wlast on beat 2; burst still runs to 4 beats
        issue(0, 1'b0, 26'h200);
        write_data(0, 26'h200, 32'h5A5A_0000, 1);
        @(negedge clk_core);
        quiet();
        #1;
        chk("frame_err_sticky", 32'(bus.arb_error), 32'd1);
        chk("frame_idle", 32'(bus.arb_grant), 32'd0);

        // reset in the middle of a read burst
        issue(0, 1'b1, 26'h40);
        read_data(0, 26'h40, 1'b0, 1);
        chk("err_before_rst", 32'(bus.arb_error), 32'd1);
        reset = 1'b1;
        @(negedge clk_core);
        quiet();
        bus.m_rready[0] = 1'b1;
        #1;
        chk("midrst_grant", 32'(bus.arb_grant), 32'd0);
        chk("midrst_error", 32'(bus.arb_error), 32'd0);
        chk("midrst_outs", 32'({bus.arb_rvalid, bus.arb_rlast, bus.bmain_rready_dctl, bus.bmain_cvalid_dctl}), 32'd0);
        reset = 1'b0;
        rq.delete();
        issue(0, 1'b1, 26'h40);
        read_data(0, 26'h40, 1'b0, -1);

        // controller error pulse sets the sticky flag
        @(negedge clk_core);
        quiet();
        bus.dctl_error = 1'b1;
        #1;
        chk("derr_pre", 32'(bus.arb_error), 32'd0);
        @(negedge clk_core);
        bus.dctl_error = 1'b0;
        #1;
        chk("derr_set", 32'(bus.arb_error), 32'd1);
        repeat (2) @(negedge clk_core);
        #1;
        chk("derr_sticky", 32'(bus.arb_error), 32'd1);
        chk("sb_empty", 32'(rq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
